// File: rtl/uart_tx_drain.sv
// ============================================================================
// uart_tx_drain : drains a byte FIFO onto an async serial line (8N1, LSB first)
// Optional even parity bit when UART_TX_PARITY_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_drain #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD       = 115200,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_tx_drain: CLK_FREQ/BAUD must be at least 2");
      end
   endgenerate

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd4
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [CW-1:0]         baud_q, baud_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  rd_q, rd_d;
   logic                  baud_end;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   assign baud_end     = (baud_q == BAUD_LAST);
   assign tx           = tx_q;
   assign busy         = busy_q;
   assign fifo_read_en = rd_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         rd_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         rd_q     <= rd_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      rd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // Capture the head word on the same edge that issues the pop.
            if (!fifo_empty) begin
               shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
               parity_d = ^fifo_data;
`endif
               rd_d     = 1'b1;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
               baud_d   = '0;
               bit_d    = '0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  // The line always shows bit 0 of the shifter.
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_drain.md
# uart_tx_drain

UART transmitter that drains the byte FIFO and serialises each entry onto a single TX line as an asynchronous 8N1 frame, LSB first. It sits directly downstream of the FIFO: it watches the FIFO `empty` flag, captures the FIFO's combinational `data_out`, and issues one isolated single-cycle `read_en` pulse per popped entry. Those pulses are compatible with the FIFO's rising-edge-detected read port. Its `tx` output drives the board UART pin.

## Interface

Parameters:
- `CLK_FREQ`, 27000000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DATA_WIDTH`, 8: data bits per frame; must match the FIFO `DATA_WIDTH`.

Ports:
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_data`  input  DATA_WIDTH  FIFO head entry; valid whenever `fifo_empty`=0.
- `fifo_read_en`  output  1  pop request to the FIFO; registered, one-cycle pulse.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  high while a frame is on the line.

## Operation

- Divisor is `DIV = CLK_FREQ/BAUD`, using integer truncation (234 at the defaults). Elaboration fails if `DIV` < 2.
- Baud counter is `$clog2(DIV)` bits wide and counts 0..DIV-1. Bit counter is `$clog2(DATA_WIDTH+1)` bits wide.
- States: IDLE, START, DATA, PARITY (present only with the configuration macro), STOP.
- IDLE:
  - If `fifo_empty`=0 at a clock edge: shift register <= `fifo_data`, `fifo_read_en` <= 1, `tx` <= 0, baud counter <= 0, next state START.
  - Otherwise remain in IDLE with `tx`=1.
- START: hold `tx`=0 for DIV cycles, then enter DATA with bit index 0.
- DATA:
  - `tx` = shift register bit [index] for DIV cycles per bit, LSB first.
  - After bit DATA_WIDTH-1, go to PARITY if configured, otherwise STOP.
- STOP: `tx`=1 for DIV cycles, then IDLE.
- `fifo_read_en` is high for exactly the one cycle following the IDLE->START edge, and low at all other times. It is therefore low for at least DIV-1 cycles between consecutive pulses, which satisfies the FIFO's edge detector.
- The data word is captured on the same edge as the pop. The FIFO pointer advance after that edge does not affect the frame.
- `busy` = 1 in every state except IDLE. It is registered and changes on the same edges as the state.

## Timing

- Reset values: `tx`=1, `busy`=0, `fifo_read_en`=0, state IDLE, counters 0.
- Latency: `fifo_empty` sampled low at edge N -> `tx` falls and `busy` rises after edge N; `fifo_read_en` is high between edges N and N+1.
- Frame length is (DATA_WIDTH+2)*DIV clocks, or (DATA_WIDTH+3)*DIV clocks with parity.
- IDLE lasts at least 1 cycle between frames, so the back-to-back frame period is the frame length + 1.
- `fifo_empty` is ignored outside IDLE.
- `fifo_empty` deasserting on the same edge that STOP ends: the frame starts at the next edge, after one IDLE cycle.
- Reset mid-frame:
  - `tx` returns to 1 immediately (asynchronous), `busy`=0, `fifo_read_en`=0.
  - The popped byte is discarded; no retransmit.
  - Reset of the FIFO and of this block is shared, so no stale pop occurs.
- `tx` is a registered output and never glitches.

## Configuration

- Macro `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP, driving an even-parity bit (XOR of all data bits) for DIV cycles.
  - Undefined: the frame is 8N1 and no PARITY state or logic exists.

## Test plan

Benches use `CLK_FREQ`=1000 and `BAUD`=100, giving DIV=10.

- Reset, then hold `fifo_empty`=1 for 50 cycles -> `tx`=1, `busy`=0, zero `fifo_read_en` pulses.
- Present 0xA5 with `fifo_empty`=0 for one entry -> exactly one 1-cycle `fifo_read_en` pulse. `tx` shows 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then 1 for 10 cycles. `busy` is high for exactly 100 cycles.
- FIFO holds 0x00 then 0xFF -> two frames with exactly 1 idle cycle between stop end and the second start bit. The two `fifo_read_en` pulses are exactly 101 cycles apart.
- Assert reset during data bit 3 of 0x3C -> `tx`=1 and `busy`=0 in the same cycle. After release, the next FIFO entry is transmitted from a fresh start bit.
- With `UART_TX_PARITY_EN`, send 0x07 -> parity bit 1 after the data bits; frame length 110 cycles. Send 0x03 -> parity bit 0.
- `fifo_empty` falls on the edge that STOP completes -> the next start bit begins one cycle later, and no pop is issued during STOP.
